mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 64 ++++++
 rtl/lsu_extract.sv | 32 +++
 rtl/mem_lsu.sv | 126 ++++++++++++
 tb/tb_mem_lsu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared widths, pipeline constants, aluop codes and lane helpers for the load/store unit
package mem_lsu_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;
  localparam int STALL_W    = 6;

  localparam logic                  RST_ENABLE    = 1'b1;
  localparam logic                  NO_STOP       = 1'b0;
  localparam logic                  WRITE_DISABLE = 1'b0;
  localparam logic [DATA_W-1:0]     ZERO_WORD     = 32'h0000_0000;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = 5'b00000;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [ALUOP_W-1:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [ALUOP_W-1:0] EXE_SC_OP  = 8'b1111_1000;

  // Any aluop that touches the data bus (SC included, even if it later fails).
  function automatic logic is_mem_op(input logic [ALUOP_W-1:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP,
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP: is_mem_op = 1'b1;
      default:                                    is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [ALUOP_W-1:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP: is_store_op = 1'b1;
      default:                                    is_store_op = 1'b0;
    endcase
  endfunction

  // Big-endian lanes: byte address 0 of a word lives on bits 31:24 (sel bit 3).
  function automatic logic [3:0] lane_sel(input logic [ALUOP_W-1:0] op, input logic [1:0] lo);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: lane_sel = 4'b1000 >> lo;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: lane_sel = lo[1] ? 4'b0011 : 4'b1100;
      default:                          lane_sel = 4'b1111;
    endcase
  endfunction

  // Narrow stores are replicated so the selected lanes always carry the data.
  function automatic logic [DATA_W-1:0] store_data(input logic [ALUOP_W-1:0] op,
                                                   input logic [DATA_W-1:0] reg2);
    case (op)
      EXE_SB_OP: store_data = {4{reg2[7:0]}};
      EXE_SH_OP: store_data = {2{reg2[15:0]}};
      default:   store_data = reg2;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extract.sv
// rtl/lsu_extract.sv - combinational load lane selection and sign/zero extension
module lsu_extract
  import mem_lsu_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [1:0]         addr_lo,
  input  logic [DATA_W-1:0]  rdata,
  output logic [DATA_W-1:0]  data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/halfword and extend it according to the load flavour.
  always_comb begin
    case (addr_lo)
      2'b00:   byte_lane = rdata[31:24];
      2'b01:   byte_lane = rdata[23:16];
      2'b10:   byte_lane = rdata[15:8];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    case (aluop)
      EXE_LB_OP:  data = {{24{byte_lane[7]}}, byte_lane};
      EXE_LBU_OP: data = {24'h000000, byte_lane};
      EXE_LH_OP:  data = {{16{half_lane[15]}}, half_lane};
      EXE_LHU_OP: data = {16'h0000, half_lane};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with bus handshake FSM and LL/SC support
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [ADDR_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  llbit_i,
  input  logic                  wb_llbit_we,
  input  logic                  wb_llbit_value,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [3:0]            bus_sel,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_llbit_we,
  output logic                  mem_llbit_value,
  output logic                  stallreq
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] load_data;
  logic              eff_llbit, mem_op, store_op, sc_op, ll_op, sc_fail, access;
  logic              bus_phase, capture;

  // Only stall[4] (MEM stage hold) matters here.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5], stall[3:0]};

  // A write-back stage update of the LL bit is newer than the register copy.
  assign eff_llbit = wb_llbit_we ? wb_llbit_value : llbit_i;
  assign mem_op    = is_mem_op(ex_aluop);
  assign store_op  = is_store_op(ex_aluop);
  assign sc_op     = (ex_aluop == EXE_SC_OP);
  assign ll_op     = (ex_aluop == EXE_LL_OP);
  assign sc_fail   = sc_op && !eff_llbit;
  assign access    = mem_op && !sc_fail;
  assign bus_phase = ((state_q == ST_IDLE) && access) || (state_q == ST_WAIT);
  assign capture   = bus_phase && bus_ack;

  lsu_extract u_extract (
    .aluop   (ex_aluop),
    .addr_lo (ex_mem_addr[1:0]),
    .rdata   (rdata_q),
    .data    (load_data)
  );

  // Next-state logic: an ack in the request cycle skips WAIT entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access) state_d = bus_ack ? ST_DONE : ST_WAIT;
      ST_WAIT: if (bus_ack) state_d = ST_DONE;
      ST_DONE: if (stall[4] == NO_STOP) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and read-data capture; acks outside a bus phase are dropped.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_IDLE;
      rdata_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      if (capture) rdata_q <= bus_rdata;
    end
  end

  // Bus drive, stall request and results toward mem_wb.
  always_comb begin
    bus_req         = 1'b0;
    bus_we          = 1'b0;
    bus_sel         = 4'b0000;
    bus_addr        = {ex_mem_addr[31:2], 2'b00};
    bus_wdata       = store_data(ex_aluop, ex_reg2);
    stallreq        = 1'b0;
    mem_wd          = ex_wd;
    mem_wreg        = ex_wreg;
    mem_wdata       = ex_wdata;
    mem_llbit_we    = 1'b0;
    mem_llbit_value = 1'b0;
    if (rst == RST_ENABLE) begin
      mem_wd    = NOP_REG_ADDR;
      mem_wreg  = WRITE_DISABLE;
      mem_wdata = ZERO_WORD;
    end else if (bus_phase) begin
      // ex_mem is frozen by stallreq, so these stay stable until the ack.
      bus_req  = 1'b1;
      bus_we   = store_op;
      bus_sel  = lane_sel(ex_aluop, ex_mem_addr[1:0]);
      stallreq = 1'b1;
    end else if ((state_q == ST_DONE) && mem_op) begin
      if (sc_op) begin
        mem_wdata       = 32'd1;
        mem_llbit_we    = 1'b1;
        mem_llbit_value = 1'b0;
      end else if (ll_op) begin
        mem_wdata       = load_data;
        mem_llbit_we    = 1'b1;
        mem_llbit_value = 1'b1;
      end else if (!store_op) begin
        mem_wdata = load_data;
      end
    end else if ((state_q == ST_IDLE) && sc_fail) begin
      mem_wdata = ZERO_WORD;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - randomized scoreboard bench for mem_lsu
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk, rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_mem_addr, ex_reg2, bus_rdata, bus_addr, bus_wdata, mem_wdata;
  logic [7:0]  ex_aluop;
  logic [5:0]  stall;
  logic        llbit_i, wb_llbit_we, wb_llbit_value, bus_ack;
  logic        bus_req, bus_we, mem_wreg, mem_llbit_we, mem_llbit_value, stallreq;
  logic [3:0]  bus_sel;
  logic [4:0]  mem_wd;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        llwe;
    logic        llval;
  } res_exp_t;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];
  int       checks = 0;
  int       failures = 0;
  logic     in_valid = 1'b0;
  logic     ll_reg = 1'b0;

  mem_lsu dut (
    .clk(clk), .rst(rst), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .stall(stall),
    .llbit_i(llbit_i), .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata), .mem_wd(mem_wd),
    .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_llbit_we(mem_llbit_we),
    .mem_llbit_value(mem_llbit_value), .stallreq(stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: bus requests are matched against the bus queue, committed results against the result queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req) begin
        if (bus_q.size() == 0) begin
          check("unexpected_bus_req", 32'(bus_req), 32'd0);
        end else begin
          check("bus_addr", bus_addr, bus_q[0].addr);
          check("bus_sel", 32'(bus_sel), 32'(bus_q[0].sel));
          check("bus_we", 32'(bus_we), 32'(bus_q[0].we));
          if (bus_q[0].we) check("bus_wdata", bus_wdata, bus_q[0].wdata);
          if (bus_ack) void'(bus_q.pop_front());
        end
      end
      if (in_valid && !stallreq) begin
        if (res_q.size() == 0) begin
          check("unexpected_result", 32'(in_valid), 32'd0);
        end else begin
          check("mem_wd", 32'(mem_wd), 32'(res_q[0].wd));
          check("mem_wreg", 32'(mem_wreg), 32'(res_q[0].wreg));
          if (res_q[0].chk_wdata) check("mem_wdata", mem_wdata, res_q[0].wdata);
          check("mem_llbit_we", 32'(mem_llbit_we), 32'(res_q[0].llwe));
          check("mem_llbit_value", 32'(mem_llbit_value), 32'(res_q[0].llval));
          if (!stall[4]) void'(res_q.pop_front());
        end
      end
    end
  end

  // Issue one instruction, push its expectations, play the bus slave with the given ack latency.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] rdata, input int lat, input int hold,
                        input logic llwe, input logic llval);
    res_exp_t er;
    bus_exp_t eb;
    logic        effll, acc, st, fin;
    int          sz, sh, req_cyc, stall_cyc, guard;
    logic [31:0] v;
    ex_wd    = 5'($urandom_range(1, 31));
    ex_wreg  = 1'($urandom_range(0, 1));
    ex_wdata = $urandom;
    effll = llwe ? llval : ll_reg;
    er.wd = ex_wd; er.wreg = ex_wreg; er.wdata = ex_wdata; er.chk_wdata = 1'b1;
    er.llwe = 1'b0; er.llval = 1'b0;
    acc = 1'b0; sz = 4; st = 1'b0;
    case (op)
      EXE_LB_OP, EXE_LBU_OP: begin
        acc = 1'b1; sz = 1;
        sh = (3 - int'(addr[1:0])) * 8;
        v = (rdata >> sh) & 32'hFF;
        if (op == EXE_LB_OP && v[7]) v = v | 32'hFFFF_FF00;
        er.wdata = v;
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        acc = 1'b1; sz = 2;
        sh = addr[1] ? 0 : 16;
        v = (rdata >> sh) & 32'hFFFF;
        if (op == EXE_LH_OP && v[15]) v = v | 32'hFFFF_0000;
        er.wdata = v;
      end
      EXE_LW_OP: begin acc = 1'b1; er.wdata = rdata; end
      EXE_LL_OP: begin acc = 1'b1; er.wdata = rdata; er.llwe = 1'b1; er.llval = 1'b1; end
      EXE_SB_OP: begin acc = 1'b1; st = 1'b1; sz = 1; er.chk_wdata = 1'b0; end
      EXE_SH_OP: begin acc = 1'b1; st = 1'b1; sz = 2; er.chk_wdata = 1'b0; end
      EXE_SW_OP: begin acc = 1'b1; st = 1'b1; er.chk_wdata = 1'b0; end
      EXE_SC_OP: begin
        if (effll) begin
          acc = 1'b1; st = 1'b1; er.wdata = 32'd1; er.llwe = 1'b1; er.llval = 1'b0;
        end else begin
          er.wdata = 32'd0;
        end
      end
      default: ;
    endcase
    if (acc) begin
      eb.addr = addr & ~32'h3;
      eb.we   = st;
      if (sz == 1) begin
        eb.sel = 4'(1 << (3 - int'(addr[1:0])));
        eb.wdata = {24'h0, reg2[7:0]} * 32'h0101_0101;
      end else if (sz == 2) begin
        eb.sel = 4'(3 << (addr[1] ? 0 : 2));
        eb.wdata = {16'h0, reg2[15:0]} * 32'h0001_0001;
      end else begin
        eb.sel = 4'hF;
        eb.wdata = reg2;
      end
      bus_q.push_back(eb);
    end
    res_q.push_back(er);
    ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2;
    wb_llbit_we = llwe; wb_llbit_value = llval; llbit_i = ll_reg;
    in_valid = 1'b1;
    req_cyc = 0; stall_cyc = 0; guard = 0; fin = 1'b0;
    while (!fin) begin
      #1;
      bus_ack   = bus_req && (req_cyc == lat);
      bus_rdata = bus_ack ? rdata : $urandom;
      if (bus_req) req_cyc++;
      if (stallreq) begin
        stall_cyc++;
        stall = 6'b011111;
      end else if (hold > 0) begin
        stall = 6'b010000;
        hold--;
      end else begin
        stall = 6'b000000;
        fin = 1'b1;
      end
      guard++;
      if (guard > 40) begin
        check("timeout", 32'(guard), 32'd40);
        fin = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus_ack = 1'b0; stall = 6'b000000; in_valid = 1'b0;
    ex_aluop = EXE_NOP_OP; wb_llbit_we = 1'b0;
    check("stall_cycles", 32'(stall_cyc), acc ? 32'(lat + 1) : 32'd0);
    if (er.llwe) ll_reg = er.llval;
  endtask

  logic [7:0] op_tab [0:10];

  initial begin
    op_tab[0] = EXE_LB_OP;  op_tab[1] = EXE_LBU_OP; op_tab[2] = EXE_LH_OP;
    op_tab[3] = EXE_LHU_OP; op_tab[4] = EXE_LW_OP;  op_tab[5] = EXE_LL_OP;
    op_tab[6] = EXE_SB_OP;  op_tab[7] = EXE_SH_OP;  op_tab[8] = EXE_SW_OP;
    op_tab[9] = EXE_SC_OP;  op_tab[10] = EXE_OR_OP;

    rst = 1'b1; stall = 6'b0; bus_ack = 1'b0; bus_rdata = 32'hDEAD_BEEF;
    ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678; ex_aluop = EXE_LW_OP;
    ex_mem_addr = 32'h100; ex_reg2 = 32'h55; llbit_i = 1'b1;
    wb_llbit_we = 1'b0; wb_llbit_value = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_mem_wd", 32'(mem_wd), 32'd0);
    check("rst_mem_wreg", 32'(mem_wreg), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_llbit_we", 32'(mem_llbit_we), 32'd0);
    check("rst_llbit_value", 32'(mem_llbit_value), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_sel", 32'(bus_sel), 32'd0);
    check("rst_stallreq", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; ex_aluop = EXE_NOP_OP; llbit_i = 1'b0;
    @(posedge clk); #1;

    run_op(EXE_LW_OP, 32'h100, 32'h0, 32'h1122_3344, 3, 0, 1'b0, 1'b0);
    run_op(EXE_LB_OP, 32'h103, 32'h0, 32'h0000_00F0, 0, 0, 1'b0, 1'b0);
    run_op(EXE_LBU_OP, 32'h103, 32'h0, 32'h0000_00F0, 0, 0, 1'b0, 1'b0);
    run_op(EXE_SH_OP, 32'h202, 32'h0000_ABCD, 32'h0, 1, 0, 1'b0, 1'b0);
    run_op(EXE_LL_OP, 32'h300, 32'hA5A5_0000, 32'hCAFE_F00D, 1, 0, 1'b0, 1'b0);
    ll_reg = 1'b0;
    run_op(EXE_SC_OP, 32'h300, 32'h0BAD_F00D, 32'h0, 2, 0, 1'b1, 1'b1);
    run_op(EXE_SC_OP, 32'h300, 32'h0BAD_F00D, 32'h0, 0, 0, 1'b0, 1'b0);
    run_op(EXE_LH_OP, 32'h402, 32'h0, 32'h1234_8001, 1, 2, 1'b0, 1'b0);

    // Reset while a load sits in WAIT, then a late ack that must be ignored.
    ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h504; ex_reg2 = 32'h0;
    bus_q.push_back('{addr: 32'h504, sel: 4'hF, we: 1'b0, wdata: 32'h0});
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_bus_req", 32'(bus_req), 32'd0);
    check("midrst_stallreq", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; ex_aluop = EXE_NOP_OP; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    bus_q.delete();
    #1;
    check("postrst_bus_req", 32'(bus_req), 32'd0);
    check("postrst_stallreq", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    #1;
    check("late_ack_stallreq", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    run_op(EXE_LW_OP, 32'h600, 32'h0, 32'h8765_4321, 2, 0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      automatic logic [7:0] op = op_tab[$urandom_range(0, 10)];
      automatic logic       lwe = ($urandom_range(0, 3) == 0);
      run_op(op, 32'h1000 + 32'($urandom_range(0, 255)), $urandom, $urandom,
             $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
             lwe, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
